// File: rtl/output_port.sv
`default_nettype none
// ============================================================================
//  Module   : output_port (with noc_params package)
//  Purpose  : Transmit end of a router-to-router link. Registers the granted
//             crossbar flit onto the link and tracks per-downstream-VC credit
//             counts and packet occupancy for the local allocators.
//  Revision : 1.0  initial release
// ============================================================================

package noc_params;
    localparam int VC_NUM         = 4;
    localparam int VC_SIZE        = $clog2(VC_NUM);
    localparam int FLIT_DATA_SIZE = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_label_t;

    typedef struct packed {
        flit_label_t               flit_label;
        logic [VC_SIZE-1:0]        vc_id;
        logic [FLIT_DATA_SIZE-1:0] data;
    } flit_t;
endpackage

module output_port #(
    parameter int BUFFER_SIZE = 8,
    parameter int VC_NUM      = noc_params::VC_NUM
) (
    input  logic                       clk,
    input  logic                       rst,
    input  noc_params::flit_t          flit_i,
    input  logic                       valid_i,
    input  logic                       credit_valid_i,
    input  logic [$clog2(VC_NUM)-1:0]  credit_vc_i,
    output noc_params::flit_t          data_o,
    output logic                       valid_flit_o,
    output logic [VC_NUM-1:0]          credit_avail_o,
    output logic [VC_NUM-1:0]          vc_free_o,
    output logic                       protocol_err_o
);

    localparam int             CW   = $clog2(BUFFER_SIZE + 1);
    localparam logic [CW-1:0]  FULL = CW'(BUFFER_SIZE);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        DRAINING = 2'd2
    } vc_state_e;

    logic [CW-1:0]      count_q [VC_NUM];
    logic [CW-1:0]      count_d [VC_NUM];
    vc_state_e          state_q [VC_NUM];
    vc_state_e          state_d [VC_NUM];

    noc_params::flit_t  data_q;
    logic               valid_q;
    logic               err_q;

    logic               accept;
    logic               drop;
    logic               credit_bad;
    logic               label_ok;
    logic [CW-1:0]      sel_count;
    vc_state_e          sel_state;
    noc_params::flit_label_t label;

    // Accept/drop decision, credit legality and per-VC next-state computation
    always_comb begin
        label     = flit_i.flit_label;
        sel_count = count_q[flit_i.vc_id];
        sel_state = state_q[flit_i.vc_id];

        label_ok = 1'b0;
        case (sel_state)
            IDLE:    label_ok = (label == noc_params::HEAD) || (label == noc_params::HEADTAIL);
            ACTIVE:  label_ok = (label == noc_params::BODY) || (label == noc_params::TAIL);
            default: label_ok = 1'b0;
        endcase

        accept     = valid_i && (sel_count != '0) && label_ok;
        drop       = valid_i && !accept;
        // A credit at full count means the downstream buffer is already empty,
        // so it cannot be genuine; it is discarded rather than wrapping.
        credit_bad = credit_valid_i && (count_q[credit_vc_i] == FULL);

        for (int v = 0; v < VC_NUM; v++) begin
            logic dec;
            logic inc;
            dec = accept && (int'(flit_i.vc_id) == v);
            inc = credit_valid_i && (int'(credit_vc_i) == v) && (count_q[v] != FULL);

            count_d[v] = count_q[v];
            if (dec && !inc) begin
                count_d[v] = count_q[v] - CW'(1);
            end else if (inc && !dec) begin
                count_d[v] = count_q[v] + CW'(1);
            end

            state_d[v] = state_q[v];
            case (state_q[v])
                IDLE: begin
                    if (dec) begin
                        state_d[v] = (label == noc_params::HEADTAIL) ? DRAINING : ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (dec && (label == noc_params::TAIL)) begin
                        state_d[v] = DRAINING;
                    end
                end
                DRAINING: begin
                    // Release the VC only once the downstream buffer is fully
                    // empty so a new packet never shares it with the old one.
                    if (count_d[v] == FULL) begin
                        state_d[v] = IDLE;
                    end
                end
                default: state_d[v] = IDLE;
            endcase
        end
    end

    // Link register, error pulse, credit counters and per-VC state machines
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            for (int v = 0; v < VC_NUM; v++) begin
                count_q[v] <= FULL;
                state_q[v] <= IDLE;
            end
        end else begin
            valid_q <= accept;
            err_q   <= drop || credit_bad;
            if (accept) begin
                data_q <= flit_i;
            end
            for (int v = 0; v < VC_NUM; v++) begin
                count_q[v] <= count_d[v];
                state_q[v] <= state_d[v];
            end
        end
    end

    generate
        for (genvar g = 0; g < VC_NUM; g++) begin : g_vc_flags
            assign credit_avail_o[g] = (count_q[g] != '0);
            assign vc_free_o[g]      = (state_q[g] == IDLE);
        end
    endgenerate

    assign data_o         = data_q;
    assign valid_flit_o   = valid_q;
    assign protocol_err_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_output_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_output_port
//  Purpose  : Self-checking bench for output_port. A behavioural model of the
//             credit counters and VC states predicts every cycle's outputs;
//             accepted flits are queued and matched against the link.
//  Revision : 1.0  initial release
// ============================================================================

module tb_output_port;
    import noc_params::*;

    localparam int BS = 8;
    localparam int NV = noc_params::VC_NUM;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    flit_t                flit_i = '0;
    logic                 valid_i = 1'b0;
    logic                 credit_valid_i = 1'b0;
    logic [VC_SIZE-1:0]   credit_vc_i = '0;
    flit_t                data_o;
    logic                 valid_flit_o;
    logic [NV-1:0]        credit_avail_o;
    logic [NV-1:0]        vc_free_o;
    logic                 protocol_err_o;

    int    checks   = 0;
    int    failures = 0;
    int    m_cnt [NV];
    int    m_st  [NV];   // 0 idle, 1 active, 2 draining
    flit_t exp_q [$];
    flit_t last_data;

    output_port #(.BUFFER_SIZE(BS), .VC_NUM(NV)) dut (
        .clk            (clk),
        .rst            (rst_n),
        .flit_i         (flit_i),
        .valid_i        (valid_i),
        .credit_valid_i (credit_valid_i),
        .credit_vc_i    (credit_vc_i),
        .data_o         (data_o),
        .valid_flit_o   (valid_flit_o),
        .credit_avail_o (credit_avail_o),
        .vc_free_o      (vc_free_o),
        .protocol_err_o (protocol_err_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < NV; i++) begin
            m_cnt[i] = BS;
            m_st[i]  = 0;
        end
        exp_q.delete();
        last_data = '0;
    endtask

    function automatic logic [NV-1:0] model_avail();
        logic [NV-1:0] r;
        for (int i = 0; i < NV; i++) r[i] = (m_cnt[i] != 0);
        return r;
    endfunction

    function automatic logic [NV-1:0] model_free();
        logic [NV-1:0] r;
        for (int i = 0; i < NV; i++) r[i] = (m_st[i] == 0);
        return r;
    endfunction

    // One clock cycle: drive, predict, then check the registered outputs
    task automatic cyc(input bit v, input flit_label_t lab, input int vc,
                       input bit cv, input int cvc);
        flit_t f;
        bit    lok, acc, bad;
        int    pst;
        f.flit_label = lab;
        f.vc_id      = VC_SIZE'(vc);
        f.data       = 16'($urandom);
        flit_i         = f;
        valid_i        = v;
        credit_valid_i = cv;
        credit_vc_i    = VC_SIZE'(cvc);

        pst = m_st[vc];
        lok = (pst == 0 && (lab == HEAD || lab == HEADTAIL)) ||
              (pst == 1 && (lab == BODY || lab == TAIL));
        acc = v && (m_cnt[vc] > 0) && lok;
        bad = cv && (m_cnt[cvc] == BS);
        if (acc) begin
            m_cnt[vc]--;
            exp_q.push_back(f);
        end
        if (cv && !bad) m_cnt[cvc]++;
        for (int i = 0; i < NV; i++) begin
            if (m_st[i] == 2 && m_cnt[i] == BS) m_st[i] = 0;
        end
        if (acc) begin
            if (pst == 0) m_st[vc] = (lab == HEADTAIL) ? 2 : 1;
            else          m_st[vc] = (lab == TAIL) ? 2 : 1;
        end

        @(posedge clk);
        #1;
        check_eq("valid", 64'(valid_flit_o), 64'(acc));
        if (acc && exp_q.size() > 0) begin
            last_data = exp_q.pop_front();
            check_eq("data", 64'(data_o), 64'(last_data));
        end else begin
            check_eq("data_hold", 64'(data_o), 64'(last_data));
        end
        check_eq("err", 64'(protocol_err_o), 64'((v && !acc) || bad));
        check_eq("credit_avail", 64'(credit_avail_o), 64'(model_avail()));
        check_eq("vc_free", 64'(vc_free_o), 64'(model_free()));
        valid_i        = 1'b0;
        credit_valid_i = 1'b0;
    endtask

    task automatic send(input flit_label_t lab, input int vc);
        cyc(1'b1, lab, vc, 1'b0, 0);
    endtask

    task automatic credit(input int vc);
        cyc(1'b0, HEAD, 0, 1'b1, vc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, HEAD, 0, 1'b0, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_valid"}, 64'(valid_flit_o), 64'(0));
        check_eq({tag, "_data"}, 64'(data_o), 64'(0));
        check_eq({tag, "_err"}, 64'(protocol_err_o), 64'(0));
        check_eq({tag, "_avail"}, 64'(credit_avail_o), 64'({NV{1'b1}}));
        check_eq({tag, "_free"}, 64'(vc_free_o), 64'({NV{1'b1}}));
    endtask

    initial begin
        reset_model();
        #1 rst_n = 1'b0;
        #1 check_reset_values("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // HEAD/BODY/TAIL on VC1, then three credits release the VC
        send(HEAD, 1);
        send(BODY, 1);
        send(TAIL, 1);
        check_eq("pkt_vc1_busy", 64'(vc_free_o[1]), 64'(0));
        credit(1);
        credit(1);
        credit(1);
        check_eq("pkt_vc1_free", 64'(vc_free_o[1]), 64'(1));

        // Exhaust VC0: HEAD + 7 BODY, then a 9th flit is dropped
        send(HEAD, 0);
        for (int i = 0; i < BS - 1; i++) send(BODY, 0);
        check_eq("exhaust_avail0", 64'(credit_avail_o[0]), 64'(0));
        send(BODY, 0);
        check_eq("exhaust_err", 64'(protocol_err_o), 64'(1));

        // Bring VC0 to count 3, then send and credit together
        credit(0);
        credit(0);
        credit(0);
        cyc(1'b1, BODY, 0, 1'b1, 0);
        send(TAIL, 0);
        for (int i = 0; i < 6; i++) credit(0);
        check_eq("vc0_released", 64'(vc_free_o[0]), 64'(1));

        // HEADTAIL on VC1 drains on a single credit; BODY to idle VC1 drops
        send(HEADTAIL, 1);
        check_eq("ht_busy", 64'(vc_free_o[1]), 64'(0));
        credit(1);
        check_eq("ht_free", 64'(vc_free_o[1]), 64'(1));
        send(BODY, 1);

        // Credit at full count is illegal and must not wrap
        credit(0);
        check_eq("overflow_avail", 64'(credit_avail_o[0]), 64'(1));
        send(HEAD, 0);
        send(TAIL, 0);

        // Drop and illegal credit in the same cycle: one pulse
        cyc(1'b1, BODY, 2, 1'b1, 3);
        idle(1);
        credit(0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), flit_label_t'($urandom_range(0, 3)),
                $urandom_range(0, NV - 1), ($urandom_range(0, 9) < 4),
                $urandom_range(0, NV - 1));
        end
        check_eq("sb_empty", 64'(exp_q.size()), 64'(0));

        // Mid-packet asynchronous reset
        send(HEAD, 2);
        send(BODY, 2);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midreset");
        reset_model();
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        send(HEAD, 2);
        send(TAIL, 2);
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
